// File: rtl/gcd_controller.sv
// gcd_controller: subtract-and-compare GCD sequencer whose working registers feed an external comparator.
// Build macro GCD_ZERO_CHECK_EN: when defined, a zero operand skips RUN and completes immediately.
module gcd_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic [15:0] cmp_a,
    output logic [15:0] cmp_b,
    input  logic        lt,
    input  logic        eq,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [15:0] iter_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [15:0] result_r;
    logic [15:0] iter_r;
    logic        busy_r;
    logic        done_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] inc_v;
        if (value == 16'hFFFF) begin
            inc_v = 16'hFFFF;
        end else begin
            inc_v = value + 16'd1;
        end
        return inc_v;
    endfunction

`ifdef GCD_ZERO_CHECK_EN
    function automatic logic has_zero(input logic [15:0] x, input logic [15:0] y);
        return (x == 16'd0) || (y == 16'd0);
    endfunction
`endif

    // Sequencer: state, working registers A/B and every output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            a_r      <= 16'd0;
            b_r      <= 16'd0;
            result_r <= 16'd0;
            iter_r   <= 16'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r    <= a_in;
                        b_r    <= b_in;
                        iter_r <= 16'd0;
`ifdef GCD_ZERO_CHECK_EN
                        if (has_zero(a_in, b_in)) begin
                            result_r <= a_in | b_in;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                            state_r  <= DONE;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= RUN;
                        end
`else
                        busy_r  <= 1'b1;
                        state_r <= RUN;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    // Only lt/eq steer the datapath; a greater-than flag is implied by neither.
                    if (eq) begin
                        result_r <= a_r;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end else if (lt) begin
                        b_r    <= b_r - a_r;
                        iter_r <= sat_inc(iter_r);
                    end else begin
                        a_r    <= a_r - b_r;
                        iter_r <= sat_inc(iter_r);
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign cmp_a    = a_r;
    assign cmp_b    = b_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign iter_cnt = iter_r;

endmodule

// File: tb/tb_gcd_controller.sv
// Scoreboard bench for gcd_controller: stimulus pushes Euclid-model expectations, a monitor pops them on done.
// Honours GCD_ZERO_CHECK_EN the same way the design does.
module tb_gcd_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [15:0] cmp_a;
    logic [15:0] cmp_b;
    logic        lt;
    logic        eq;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] iter_cnt;

    typedef struct {
        int res;
        int iters;
        int done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp      = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   done_count = 0;
    bit   prev_done  = 1'b0;

    gcd_controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cmp_a    (cmp_a),
        .cmp_b    (cmp_b),
        .lt       (lt),
        .eq       (eq),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .iter_cnt (iter_cnt)
    );

    // External 16-bit comparator
    assign lt = (cmp_a < cmp_b);
    assign eq = (cmp_a == cmp_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Subtractive GCD step count equals the sum of Euclid quotients minus one.
    function automatic void ref_gcd(input int a, input int b, output int g, output int n);
        int x, y, t, q;
        if (a == 0 || b == 0) begin
            g = a | b;
            n = 0;
        end else begin
            x = a; y = b; q = 0;
            while (y != 0) begin
                q += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            g = x;
            n = (q - 1 > 65535) ? 65535 : q - 1;
        end
    endfunction

    // Monitor: pop and compare whenever the DUT presents done.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            check("done_single_cycle", 32'(prev_done), 0);
            check("busy_at_done", 32'(busy), 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d required no done", cyc);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'(result), e.res);
                check("iter_cnt", 32'(iter_cnt), e.iters);
                check("done_edge", cyc, e.done_cyc);
            end
            done_count++;
        end
        prev_done = done;
    end

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        check("rst_iter_cnt", 32'(iter_cnt), 0);
        check("rst_cmp_a", 32'(cmp_a), 0);
        check("rst_cmp_b", 32'(cmp_b), 0);
        exp_q.delete();
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_one(input int a, input int b, input bit noise);
        int   g, n, s, e, base, busy_lo;
        bit   seen;
        exp_t x;
        ref_gcd(a, b, g, n);
        base  = done_count;
        a_in  = 16'(a);
        b_in  = 16'(b);
        start = 1'b1;
        @(posedge clk);
        #1;
        s     = cyc;
        start = 1'b0;
        e     = s + n + 1;
`ifdef GCD_ZERO_CHECK_EN
        if (a == 0 || b == 0) e = s;
`endif
        x.res = g; x.iters = n; x.done_cyc = e;
        exp_q.push_back(x);
        @(negedge clk);
        #1;
        check("busy_after_start", 32'(busy), (e == s) ? 0 : 1);
        busy_lo = 0;
        seen    = 1'b0;
        for (int k = 0; k < n + 20; k++) begin
            if (done_count != base) begin
                seen = 1'b1;
                break;
            end
            if (cyc < e && busy !== 1'b1) busy_lo++;
            if (noise && cyc < e) begin
                start = 1'($urandom_range(0, 1));
                a_in  = 16'($urandom);
                b_in  = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done within %0d cycles required done for %0d/%0d", n + 20, a, b);
            reset_pulse();
        end else begin
            check("busy_held_in_run", busy_lo, 0);
            repeat (3) @(negedge clk);
            #1;
            check("result_hold", 32'(result), g);
            check("iter_cnt_hold", 32'(iter_cnt), n);
        end
    endtask

    initial begin
        #990000;
        $display("FAIL watchdog: got no finish by cycle %0d required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   s, base, g1, n1, g2, n2, e1, s2, e2;
        exp_t x;
        rst_n = 1'b1;
        start = 1'b0;
        a_in  = 16'd0;
        b_in  = 16'd0;
        reset_pulse();

        run_one(48, 18, 1'b0);
        run_one(32'h00FF, 32'h00FF, 1'b0);
        run_one(0, 0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            int ra, rb;
            ra = int'($urandom_range(1, 300));
            rb = (i % 6 == 0) ? ra : int'($urandom_range(1, 300));
            run_one(ra, rb, 1'($urandom_range(0, 1)));
        end

        // Long coprime run with start pulses sprinkled through RUN
        run_one(32'h0FFF, 1, 1'b1);

        // Reset in the middle of a computation
        a_in  = 16'd1000;
        b_in  = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("midrun_iter_cnt", 32'(iter_cnt), 9);
        check("midrun_cmp_a", 32'(cmp_a), 973);
        check("midrun_busy", 32'(busy), 1);
        reset_pulse();
        run_one(21, 14, 1'b0);

        // Back-to-back with start held high
        ref_gcd(12, 8, g1, n1);
        ref_gcd(9, 6, g2, n2);
        base  = done_count;
        a_in  = 16'd12;
        b_in  = 16'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        s    = cyc;
        a_in = 16'd9;
        b_in = 16'd6;
        e1 = s + n1 + 1;
        s2 = e1 + 2;
        e2 = s2 + n2 + 1;
        x.res = g1; x.iters = n1; x.done_cyc = e1;
        exp_q.push_back(x);
        x.res = g2; x.iters = n2; x.done_cyc = e2;
        exp_q.push_back(x);
        while (cyc < s2) @(negedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 40 && done_count < base + 2; k++) @(negedge clk);
        #1;
        check("b2b_done_pulses", done_count - base, 2);
        check("b2b_result_hold", 32'(result), g2);

`ifdef GCD_ZERO_CHECK_EN
        run_one(0, 20, 1'b0);
        run_one(20, 0, 1'b0);
`else
        // One zero operand: RUN never terminates, iter_cnt saturates
        base  = done_count;
        a_in  = 16'd0;
        b_in  = 16'd20;
        start = 1'b1;
        @(posedge clk);
        #1;
        s     = cyc;
        start = 1'b0;
        while (cyc < s + 1000) @(negedge clk);
        #1;
        check("zero_iter_1000", 32'(iter_cnt), 1000);
        check("zero_busy_1000", 32'(busy), 1);
        while (cyc < s + 65600) @(negedge clk);
        #1;
        check("zero_iter_saturated", 32'(iter_cnt), 65535);
        check("zero_busy_held", 32'(busy), 1);
        check("zero_cmp_a", 32'(cmp_a), 0);
        check("zero_cmp_b", 32'(cmp_b), 20);
        check("zero_no_done", done_count - base, 0);
        reset_pulse();
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
